// File: rtl/vec_pkg.sv
// Shared definitions for the vector element sequencer: default widths and FSM state encoding.
package vec_pkg;

  localparam int unsigned VEC_AW = 16;
  localparam int unsigned VEC_LW = 16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_A = 3'd1;
  localparam logic [2:0] S_RD_B = 3'd2;
  localparam logic [2:0] S_LD_B = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

endpackage

// File: rtl/vec_elem_seq_if.sv
// Command and memory-control bundle between a vector-op requester and the element sequencer.
interface vec_elem_seq_if import vec_pkg::*; #(
  parameter int unsigned AW = VEC_AW,
  parameter int unsigned LW = VEC_LW
);

  logic          start;
  logic [LW-1:0] len;
  logic [AW-1:0] base_a;
  logic [AW-1:0] base_b;
  logic [AW-1:0] base_d;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          ld_a;
  logic          ld_b;
  logic [LW-1:0] elem_idx;
  logic          busy;
  logic          done;

  modport master (
    output start, len, base_a, base_b, base_d,
    input  mem_addr, mem_we, ld_a, ld_b, elem_idx, busy, done
  );

  modport slave (
    input  start, len, base_a, base_b, base_d,
    output mem_addr, mem_we, ld_a, ld_b, elem_idx, busy, done
  );

endinterface

// File: rtl/vec_addr_ctr.sv
// Running address for one vector stream: loads the base on an accepted start and
// advances by STRIDE between elements, so no index multiply is needed.
module vec_addr_ctr import vec_pkg::*; #(
  parameter int unsigned AW     = VEC_AW,
  parameter int unsigned STRIDE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] base,
  output logic [AW-1:0] addr
);

  // Addition is modulo 2^AW; wrap-around is intentional.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= base;
    end else if (step) begin
      addr <= addr + AW'(STRIDE);
    end
  end

endmodule

// File: rtl/vec_elem_seq.sv
// Element sequencer for D[i] = op(A[i], B[i]): walks A/B/D address streams over a
// single-port synchronous memory and strobes the operand-register loads and result write.
module vec_elem_seq import vec_pkg::*; #(
  parameter int unsigned AW     = VEC_AW,
  parameter int unsigned LW     = VEC_LW,
  parameter int unsigned STRIDE = 1
) (
  input  logic           clk,
  input  logic           rst,
  vec_elem_seq_if.slave  bus
);

  logic [2:0]    state;
  logic [2:0]    state_next;
  logic          accept;
  logic          step;
  logic [LW-1:0] len_q;
  logic [LW-1:0] idx;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [AW-1:0] addr_d;
  logic          last_elem;

  assign last_elem = (idx == (len_q - LW'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Captured length and element index; inputs are ignored until the next accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q <= '0;
      idx   <= '0;
    end else if (accept) begin
      len_q <= bus.len;
      idx   <= '0;
    end else if (step) begin
      idx   <= idx + LW'(1);
    end
  end

  vec_addr_ctr #(.AW(AW), .STRIDE(STRIDE)) u_ctr_a (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .step (step),
    .base (bus.base_a),
    .addr (addr_a)
  );

  vec_addr_ctr #(.AW(AW), .STRIDE(STRIDE)) u_ctr_b (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .step (step),
    .base (bus.base_b),
    .addr (addr_b)
  );

  vec_addr_ctr #(.AW(AW), .STRIDE(STRIDE)) u_ctr_d (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .step (step),
    .base (bus.base_d),
    .addr (addr_d)
  );

  // Next state plus output decode; outputs depend only on state and registered counters.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    step         = 1'b0;
    bus.mem_addr = '0;
    bus.mem_we   = 1'b0;
    bus.ld_a     = 1'b0;
    bus.ld_b     = 1'b0;
    bus.elem_idx = idx;
    bus.busy     = (state != S_IDLE);
    bus.done     = (state == S_DONE);

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = (bus.len == '0) ? S_DONE : S_RD_A;
        end
      end
      S_RD_A: begin
        bus.mem_addr = addr_a;
        state_next   = S_RD_B;
      end
      S_RD_B: begin
        bus.mem_addr = addr_b;
        bus.ld_a     = 1'b1;
        state_next   = S_LD_B;
      end
      S_LD_B: begin
        bus.mem_addr = addr_b;
        bus.ld_b     = 1'b1;
        state_next   = S_WR;
      end
      S_WR: begin
        bus.mem_addr = addr_d;
        bus.mem_we   = 1'b1;
        if (last_elem) begin
          state_next = S_DONE;
        end else begin
          step       = 1'b1;
          state_next = S_RD_A;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vec_elem_seq.sv
// Bench for vec_elem_seq: expected A/B/D addresses are queued at launch and popped as the
// sequencer strobes ld_a, ld_b and mem_we; pulse counts and latencies are checked per run.
module tb_vec_elem_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  vec_elem_seq_if #(.AW(16), .LW(16)) bus ();
  vec_elem_seq_if #(.AW(16), .LW(16)) bus2 ();

  vec_elem_seq #(.AW(16), .LW(16), .STRIDE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vec_elem_seq #(.AW(16), .LW(16), .STRIDE(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int n_done = 0, n_busy = 0, n_lda = 0, n_ldb = 0, n_we = 0, n_extra = 0;
  int last_done_cyc = 0, prev_done_cyc = 0;
  logic [15:0] prev_addr = '0;

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  logic [15:0] exp_d[$];
  logic [15:0] got2[$];

  int t0;
  int s_done, s_busy, s_lda, s_ldb, s_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: the operand register captures data for the address presented one cycle earlier.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.ld_a) begin
        n_lda++;
        if (exp_a.size() > 0) chk("ld_a_addr", 32'(prev_addr), 32'(exp_a.pop_front()));
        else n_extra++;
      end
      if (bus.ld_b) begin
        n_ldb++;
        if (exp_b.size() > 0) chk("ld_b_addr", 32'(prev_addr), 32'(exp_b.pop_front()));
        else n_extra++;
      end
      if (bus.mem_we) begin
        n_we++;
        if (exp_d.size() > 0) chk("wr_addr", 32'(bus.mem_addr), 32'(exp_d.pop_front()));
        else n_extra++;
      end
      if (bus.done) begin
        n_done++;
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
      end
      if (bus.busy) n_busy++;
      if (bus2.mem_we) got2.push_back(bus2.mem_addr);
    end
    prev_addr = bus.mem_addr;
  end

  task automatic push_exp(input int n, input logic [15:0] a, input logic [15:0] b, input logic [15:0] d);
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(16'(a + 16'(i)));
      exp_b.push_back(16'(b + 16'(i)));
      exp_d.push_back(16'(d + 16'(i)));
    end
  endtask

  task automatic snap();
    s_done = n_done; s_busy = n_busy; s_lda = n_lda; s_ldb = n_ldb; s_we = n_we;
  endtask

  task automatic launch(input logic [15:0] n, input logic [15:0] a, input logic [15:0] b, input logic [15:0] d);
    @(negedge clk);
    bus.len = n; bus.base_a = a; bus.base_b = b; bus.base_d = d;
    bus.start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base_cnt, input int budget);
    int k = 0;
    while (n_done == base_cnt && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk({tag, "_done_seen"}, 32'(n_done - base_cnt), 32'd1);
  endtask

  task automatic check_run(input string tag, input int n);
    chk({tag, "_done_lat"}, 32'(last_done_cyc - t0), 32'(4 * n + 1));
    chk({tag, "_busy_cycles"}, 32'(n_busy - s_busy), 32'(4 * n + 1));
    chk({tag, "_ld_a_cnt"}, 32'(n_lda - s_lda), 32'(n));
    chk({tag, "_ld_b_cnt"}, 32'(n_ldb - s_ldb), 32'(n));
    chk({tag, "_we_cnt"}, 32'(n_we - s_we), 32'(n));
    chk({tag, "_done_cnt"}, 32'(n_done - s_done), 32'd1);
    chk({tag, "_queues_left"}, 32'(exp_a.size() + exp_b.size() + exp_d.size()), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.len = '0; bus.base_a = '0; bus.base_b = '0; bus.base_d = '0;
    bus2.start = 1'b0; bus2.len = '0; bus2.base_a = '0; bus2.base_b = '0; bus2.base_d = '0;

    // Reset state
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_ld_a", 32'(bus.ld_a), 32'd0);
    chk("rst_ld_b", 32'(bus.ld_b), 32'd0);
    chk("rst_elem_idx", 32'(bus.elem_idx), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // T1: three elements, basic streams
    snap();
    push_exp(3, 16'h0010, 16'h0020, 16'h0030);
    launch(16'd3, 16'h0010, 16'h0020, 16'h0030);
    wait_done("t1", s_done, 40);
    repeat (3) @(negedge clk);
    check_run("t1", 3);

    // T2: zero-length vector
    snap();
    launch(16'd0, 16'h1111, 16'h2222, 16'h3333);
    wait_done("t2", s_done, 20);
    repeat (3) @(negedge clk);
    check_run("t2", 0);

    // T3: source A wraps past the top of the address space
    snap();
    push_exp(3, 16'hFFFE, 16'h0200, 16'h0300);
    launch(16'd3, 16'hFFFE, 16'h0200, 16'h0300);
    wait_done("t3", s_done, 40);
    repeat (3) @(negedge clk);
    check_run("t3", 3);

    // T4: second start while busy is ignored
    snap();
    push_exp(2, 16'h0400, 16'h0500, 16'h0600);
    launch(16'd2, 16'h0400, 16'h0500, 16'h0600);
    repeat (3) @(negedge clk);
    bus.len = 16'd7; bus.base_a = 16'h0A00; bus.base_b = 16'h0B00; bus.base_d = 16'h0D00;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("t4", s_done, 40);
    repeat (4) @(negedge clk);
    check_run("t4", 2);

    // T5: asynchronous reset during the write of element 1 of a four-element run
    push_exp(2, 16'h0040, 16'h0050, 16'h0060);
    launch(16'd4, 16'h0040, 16'h0050, 16'h0060);
    repeat (7) @(negedge clk);
    #1;
    chk("t5_pre_we", 32'(bus.mem_we), 32'd1);
    chk("t5_pre_idx", 32'(bus.elem_idx), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("t5_rst_we", 32'(bus.mem_we), 32'd0);
    chk("t5_rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    chk("t5_rst_ld_a", 32'(bus.ld_a), 32'd0);
    chk("t5_rst_idx", 32'(bus.elem_idx), 32'd0);
    chk("t5_partial_left", 32'(exp_a.size() + exp_b.size() + exp_d.size()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    snap();
    push_exp(4, 16'h0040, 16'h0050, 16'h0060);
    launch(16'd4, 16'h0040, 16'h0050, 16'h0060);
    wait_done("t5", s_done, 40);
    repeat (3) @(negedge clk);
    check_run("t5", 4);

    // T6: start held high gives back-to-back single-element vectors
    snap();
    push_exp(1, 16'h0070, 16'h0080, 16'h0090);
    push_exp(1, 16'h0070, 16'h0080, 16'h0090);
    @(negedge clk);
    bus.len = 16'd1; bus.base_a = 16'h0070; bus.base_b = 16'h0080; bus.base_d = 16'h0090;
    bus.start = 1'b1;
    t0 = cyc;
    wait_done("t6a", s_done, 20);
    @(negedge clk); #1;
    chk("t6_gap_busy_low", 32'(bus.busy), 32'd0);
    @(negedge clk); #1;
    chk("t6_relaunch_busy", 32'(bus.busy), 32'd1);
    wait_done("t6b", s_done + 1, 20);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    // DONE, then one IDLE cycle, then four element cycles before the next DONE
    chk("t6_done_spacing", 32'(last_done_cyc - prev_done_cyc), 32'd6);
    chk("t6_first_lat", 32'(prev_done_cyc - t0), 32'd5);
    chk("t6_done_cnt", 32'(n_done - s_done), 32'd2);
    chk("t6_we_cnt", 32'(n_we - s_we), 32'd2);
    chk("t6_queues_left", 32'(exp_a.size() + exp_b.size() + exp_d.size()), 32'd0);

    // STRIDE=2 instance: destination advances by two
    @(negedge clk);
    bus2.len = 16'd2; bus2.base_a = 16'h0000; bus2.base_b = 16'h0010; bus2.base_d = 16'h0100;
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("s2_we_cnt", 32'(got2.size()), 32'd2);
    if (got2.size() == 2) begin
      chk("s2_wr0", 32'(got2[0]), 32'h0100);
      chk("s2_wr1", 32'(got2[1]), 32'h0102);
    end

    chk("extra_pulses", 32'(n_extra), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
